uart_tx_ctrl: RTL and testbench

Frame sequencer for the UART transmit path. It accepts a parallel word from upstream and loads it into the TX serializer. It then drives the serial line through start, data (LSB first), optional parity and one or two stop bits, paced by an external baud-rate tick. It pulses the serializer's shift enable at the correct point inside each data bit, so the next bit is stable before it is sampled.

---
 rtl/uart_tx_ctrl.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: loads the TX serializer, then walks the line through
// start, LSB-first data, optional parity and one or two stop bits on each baud tick.
module uart_tx_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             baud_tick,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             par_en,
    input  logic             par_odd,
    input  logic             two_stop,
    input  logic             ser_data,
    output logic             ser_load,
    output logic             ser_shift_en,
    output logic             tx_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_out_q, tx_out_d;
    logic          busy_q, busy_d;
    logic          load_q, load_d;
    logic          shift_q, shift_d;
    logic          done_q, done_d;
    logic          par_en_q, par_en_d;
    logic          par_bit_q, par_bit_d;
    logic          two_stop_q, two_stop_d;

    // State and output registers; reset parks the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            done_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
            load_q     <= load_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
        end
    end

    // Shift enable is raised on the same edge a data bit is registered, so the
    // serializer advances one clk later, well before the next tick samples it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_out_d   = tx_out_q;
        busy_d     = busy_q;
        load_d     = 1'b0;
        shift_d    = 1'b0;
        done_d     = 1'b0;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;

        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d    = ALIGN;
                    load_d     = 1'b1;
                    busy_d     = 1'b1;
                    par_en_d   = par_en;
                    par_bit_d  = (^tx_data) ^ par_odd;
                    two_stop_d = two_stop;
                end
            end
            ALIGN: begin
                if (baud_tick) begin
                    state_d  = START;
                    tx_out_d = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d  = DATA;
                    tx_out_d = ser_data;
                    cnt_d    = '0;
                    shift_d  = 1'b1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (cnt_q != LAST_BIT) begin
                        tx_out_d = ser_data;
                        cnt_d    = CW'(cnt_q + 1'b1);
                        shift_d  = 1'b1;
                    end else if (par_en_q) begin
                        state_d  = PARITY;
                        tx_out_d = par_bit_q;
                    end else begin
                        state_d  = STOP1;
                        tx_out_d = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d  = STOP1;
                    tx_out_d = 1'b1;
                end
            end
            STOP1: begin
                if (baud_tick) begin
                    if (two_stop_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (baud_tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_ready     = (state_q == IDLE);
    assign ser_load     = load_q;
    assign ser_shift_en = shift_q;
    assign tx_out       = tx_out_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural shift-register serializer
// and a free-running baud tick of programmable period.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       baud_tick = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       par_en, par_odd, two_stop;
    logic       ser_data;
    logic       ser_load, ser_shift_en, tx_out, busy, frame_done;

    int errors = 0;
    int checks = 0;
    int tick_per = 4;
    int tcnt = 0;
    int n_load = 0, n_shift = 0, n_done = 0;
    int n_glitch = 0, n_clash = 0;
    logic [7:0] sr;
    logic prev_out, prev_tick;

    uart_tx_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_tick    (baud_tick),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .par_en       (par_en),
        .par_odd      (par_odd),
        .two_stop     (two_stop),
        .ser_data     (ser_data),
        .ser_load     (ser_load),
        .ser_shift_en (ser_shift_en),
        .tx_out       (tx_out),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Baud tick: one-clk strobe every tick_per clocks, updated away from the edge.
    always @(posedge clk) begin
        #2;
        if (tcnt >= tick_per - 1) begin
            baud_tick = 1'b1;
            tcnt = 0;
        end else begin
            baud_tick = 1'b0;
            tcnt = tcnt + 1;
        end
    end

    // Serializer model: parallel load, shift right, LSB on ser_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else if (ser_load) sr <= tx_data;
        else if (ser_shift_en) sr <= {1'b0, sr[7:1]};
    end
    assign ser_data = sr[0];

    always @(negedge clk) begin
        if (ser_load) n_load = n_load + 1;
        if (ser_shift_en) n_shift = n_shift + 1;
        if (frame_done) n_done = n_done + 1;
    end

    // The line may only change on an edge that sampled a tick; shifts never coincide with ticks.
    always @(posedge clk) begin
        prev_out = tx_out;
        prev_tick = baud_tick;
        if (ser_shift_en && baud_tick) n_clash = n_clash + 1;
        #1;
        if (rst_n && (tx_out !== prev_out) && !prev_tick) n_glitch = n_glitch + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (baud_tick) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        chk("tick_wait", 32'(ok), 32'd1);
    endtask

    // Sends one word and checks every bit period through to frame_done.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic po,
                             input logic ts, input bit hold);
        logic exp_bits [13];
        int   n;
        int   l0, s0, d0;
        bit   ok;
        tx_data  = d;
        par_en   = pe;
        par_odd  = po;
        two_stop = ts;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_wait", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
        l0 = n_load;
        s0 = n_shift;
        d0 = n_done;
        chk("align_busy", 32'(busy), 32'd1);
        chk("align_ready", 32'(tx_ready), 32'd0);
        chk("align_line", 32'(tx_out), 32'd1);
        chk("load_pulse", 32'(ser_load), 32'd1);
        n = 0;
        exp_bits[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < 8; i++) begin
            exp_bits[n] = d[i];
            n = n + 1;
        end
        if (pe) begin
            exp_bits[n] = (^d) ^ po;
            n = n + 1;
        end
        exp_bits[n] = 1'b1;
        n = n + 1;
        if (ts) begin
            exp_bits[n] = 1'b1;
            n = n + 1;
        end
        for (int k = 0; k < n; k++) begin
            wait_tick();
            chk($sformatf("bit%0d_line", k), 32'(tx_out), 32'(exp_bits[k]));
            chk($sformatf("bit%0d_busy", k), 32'(busy), 32'd1);
            chk($sformatf("bit%0d_ready", k), 32'(tx_ready), 32'd0);
        end
        wait_tick();
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(frame_done), 32'd1);
        chk("end_ready", 32'(tx_ready), 32'd1);
        chk("end_line", 32'(tx_out), 32'd1);
        @(negedge clk);
        #1;
        chk("load_count", 32'(n_load - l0), 32'd1);
        chk("shift_count", 32'(n_shift - s0), 32'd8);
        chk("done_count", 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        par_en   = 1'b0;
        par_odd  = 1'b0;
        two_stop = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_line", 32'(tx_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_load", 32'(ser_load), 32'd0);
        chk("rst_shift", 32'(ser_shift_en), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain 8N1 frames, then parity (even and odd), then two stop bits.
        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);

        // Valid held high across three consecutive words.
        run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
        run_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_no_load", 32'(n_load), 32'd7);

        // Abort mid-frame during data bit 3.
        tx_data  = 8'hA5;
        par_en   = 1'b0;
        two_stop = 1'b0;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (5) wait_tick();
        chk("abort_bit3", 32'(tx_out), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_line", 32'(tx_out), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

        // Fastest tick and a tick coincident with the accept edge.
        tick_per = 2;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (baud_tick) break;
            @(negedge clk);
        end
        chk("tick_aligned", 32'(baud_tick), 32'd1);
        run_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);

        chk("line_glitches", 32'(n_glitch), 32'd0);
        chk("shift_tick_clash", 32'(n_clash), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
